// File: rtl/display_capture.sv
`default_nettype none
// ============================================================================
// Module      : display_capture
// Description : Snoops a multiplexed 4-digit 7-segment display bus and
//               recovers the hex value shown on each digit. Inputs are
//               registered once, then a settle/hold FSM waits for a stable
//               strobe+pattern before decoding and capturing the digit.
// Ports       : clk        - sole clock, rising edge
//               rst_n      - asynchronous active-low reset
//               sel_n[3:0] - digit strobes, active-low (bit0 = digit 1)
//               seg_n[6:0] - segment pattern, active-low (bit0 = a .. bit6 = g)
//               digit1..4  - last captured hex value per position
//               valid[3:0] - bit k set once digit k+1 captured since reset
//               frame_done - 1-cycle pulse when all four positions captured
//               err        - 1-cycle pulse on collision or undecodable glyph
//               err_count  - saturating error counter (only when the macro
//                            DISPLAY_CAPTURE_ERRCNT_EN is defined)
// Revision    : 1.0 - initial release
// ============================================================================
module display_capture #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sel_n,
  input  logic [6:0] seg_n,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit4,
  output logic [3:0] valid,
  output logic       frame_done,
  output logic       err
`ifdef DISPLAY_CAPTURE_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam logic [3:0] c_SETTLE_CNT = SETTLE_CYCLES[3:0];

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Sample stage
  logic [3:0] r_sel;
  logic [6:0] r_seg;

  // FSM and capture state
  state_t     r_state;
  logic [3:0] r_count;
  logic [3:0] r_ref_sel;
  logic [6:0] r_ref_seg;
  logic       r_coll;
  logic [3:0] r_digit [4];
  logic [3:0] r_valid;
  logic [3:0] r_mask;
  logic       r_frame_done;
  logic       r_err;

  logic [3:0] w_sel_lo;
  logic [6:0] w_seg_on;
  logic       w_one_low;
  logic       w_blank;
  logic       w_coll;
  logic       w_coll_err;
  logic       w_same;
  logic       w_enter;
  logic       w_capture;
  logic       w_dec_hit;
  logic [3:0] w_dec_val;
  logic [1:0] w_pos;
  logic       w_err_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel <= 4'hF;
      r_seg <= 7'h7F;
    end else begin
      r_sel <= sel_n;
      r_seg <= seg_n;
    end
  end

  assign w_sel_lo  = ~r_sel;
  assign w_seg_on  = ~r_seg;
  // Exactly one strobe low: non-zero and a power of two.
  assign w_one_low = (w_sel_lo != 4'd0) && ((w_sel_lo & (w_sel_lo - 4'd1)) == 4'd0);
  assign w_blank   = (r_sel == 4'hF);
  assign w_coll    = !w_one_low && !w_blank;
  // Error only on the first sample of a collision run.
  assign w_coll_err = w_coll && !r_coll;
  assign w_same    = (r_sel == r_ref_sel) && (r_seg == r_ref_seg);
  // IDLE always re-evaluates; SETTLE/HOLD re-evaluate on any change.
  assign w_enter   = (r_state == ST_IDLE) || !w_same;
  assign w_capture = (r_state == ST_SETTLE) && w_same && (r_count == c_SETTLE_CNT);
  assign w_err_next = w_coll_err || (w_capture && !w_dec_hit);

  always_comb begin
    w_dec_hit = 1'b1;
    w_dec_val = 4'h0;
    case (w_seg_on)
      7'h3F: w_dec_val = 4'h0;
      7'h06: w_dec_val = 4'h1;
      7'h5B: w_dec_val = 4'h2;
      7'h4F: w_dec_val = 4'h3;
      7'h66: w_dec_val = 4'h4;
      7'h6D: w_dec_val = 4'h5;
      7'h7D: w_dec_val = 4'h6;
      7'h07: w_dec_val = 4'h7;
      7'h7F: w_dec_val = 4'h8;
      7'h6F: w_dec_val = 4'h9;
      7'h77: w_dec_val = 4'hA;
      7'h7C: w_dec_val = 4'hB;
      7'h39: w_dec_val = 4'hC;
      7'h5E: w_dec_val = 4'hD;
      7'h79: w_dec_val = 4'hE;
      7'h71: w_dec_val = 4'hF;
      default: w_dec_hit = 1'b0;
    endcase
  end

  always_comb begin
    w_pos = 2'd0;
    case (w_sel_lo)
      4'b0010: w_pos = 2'd1;
      4'b0100: w_pos = 2'd2;
      4'b1000: w_pos = 2'd3;
      default: w_pos = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_count      <= 4'd0;
      r_ref_sel    <= 4'hF;
      r_ref_seg    <= 7'h7F;
      r_coll       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_digit[i] <= 4'h0;
      end
      r_valid      <= 4'h0;
      r_mask       <= 4'h0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_err        <= w_err_next;
      r_coll       <= w_coll;
      if (w_enter) begin
        r_ref_sel <= r_sel;
        r_ref_seg <= r_seg;
        if (w_one_low) begin
          r_state <= ST_SETTLE;
          r_count <= 4'd1;
        end else begin
          r_state <= ST_IDLE;
          r_count <= 4'd0;
        end
      end else if (r_state == ST_SETTLE) begin
        if (w_capture) begin
          // Undecodable glyphs still park in HOLD so the error fires once.
          r_state <= ST_HOLD;
          if (w_dec_hit) begin
            r_digit[w_pos] <= w_dec_val;
            r_valid[w_pos] <= 1'b1;
            if ((r_mask | w_sel_lo) == 4'hF) begin
              r_mask       <= 4'h0;
              r_frame_done <= 1'b1;
            end else begin
              r_mask <= r_mask | w_sel_lo;
            end
          end
        end else begin
          r_count <= r_count + 4'd1;
        end
      end
    end
  end

  assign digit1     = r_digit[0];
  assign digit2     = r_digit[1];
  assign digit3     = r_digit[2];
  assign digit4     = r_digit[3];
  assign valid      = r_valid;
  assign frame_done = r_frame_done;
  assign err        = r_err;

`ifdef DISPLAY_CAPTURE_ERRCNT_EN
  logic [7:0] r_err_count;

  // Counts in step with the err pulse so both appear on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= 8'd0;
    end else if (w_err_next && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire
